// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: an instruction-fetch port and a data port share one
// RAM. Data has priority from IDLE, and the ports alternate while both are busy.
// A grant that runs too long, or a RAM ERROR status, locks the arbiter in ERR.
//
// Ports:
//   CLK, RST                    clock, asynchronous active-high reset
//   iREN, iaddr                 instruction read request and address
//   dREN, dWEN, daddr, dstore   data read/write request, address, store data
//   iwait, dwait                high while the request is not complete
//   iload, dload                read data, valid only in the completion cycle
//   ramREN, ramWEN              RAM read/write strobes
//   ramaddr, ramstore           RAM address and write data
//   ramload, ramstate           RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   err                         sticky error flag, cleared only by reset
module mem_arbiter #(
   parameter int WORD_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iREN,
   input  logic [WORD_W-1:0] iaddr,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [WORD_W-1:0] daddr,
   input  logic [WORD_W-1:0] dstore,
   output logic              iwait,
   output logic              dwait,
   output logic [WORD_W-1:0] iload,
   output logic [WORD_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [WORD_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   input  logic [WORD_W-1:0] ramload,
   input  logic [1:0]        ramstate,
   output logic              err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] RS_ACCESS = 2'b10;
   localparam logic [1:0] RS_ERROR  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      IGNT = 2'b01,
      DGNT = 2'b10,
      ERR  = 2'b11
   } state_t;

   state_t        state;
   state_t        nxt;
   logic [CW-1:0] cnt;

   logic d_req;
   logic acc;
   logic tmo;
   logic grant;
   logic d_done;
   logic i_done;

   assign d_req  = dREN | dWEN;
   assign acc    = (ramstate == RS_ACCESS);
   assign grant  = (state == IGNT) || (state == DGNT);
   // Last allowed grant cycle: this one would bring the counter to TIMEOUT.
   assign tmo    = grant && !acc && (cnt == CW'(TIMEOUT - 1));
   assign d_done = (state == DGNT) && d_req && acc;
   assign i_done = (state == IGNT) && iREN && acc;
   assign err    = (state == ERR);

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= nxt;
      end
   end

   // Grant-cycle counter: cleared on entering a grant, counts non-ACCESS cycles
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt <= '0;
      end else if ((nxt == IGNT || nxt == DGNT) && nxt != state) begin
         cnt <= '0;
      end else if (grant && !acc) begin
         cnt <= cnt + CW'(1);
      end
   end

   // Next-state logic
   always_comb begin
      nxt = state;
      case (state)
         IDLE: begin
            if (d_req)
               nxt = DGNT;
            else if (iREN)
               nxt = IGNT;
         end
         DGNT: begin
            if (ramstate == RS_ERROR)
               nxt = ERR;
            else if (!d_req)
               nxt = IDLE;
            else if (acc)
               nxt = iREN ? IGNT : IDLE;
            else if (tmo)
               nxt = ERR;
         end
         IGNT: begin
            if (ramstate == RS_ERROR)
               nxt = ERR;
            else if (!iREN)
               nxt = IDLE;
            else if (acc)
               nxt = d_req ? DGNT : IDLE;
            else if (tmo)
               nxt = ERR;
         end
         default: nxt = ERR;
      endcase
   end

   // Outputs: Moore on state, strobes gated by the live requests
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iload    = '0;
      dload    = '0;
      iwait    = iREN;
      dwait    = d_req;
      case (state)
         DGNT: begin
            ramaddr  = daddr;
            ramstore = dstore;
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            if (d_done) begin
               dwait = 1'b0;
               dload = ramload;
            end
         end
         IGNT: begin
            ramaddr = iaddr;
            ramREN  = iREN;
            if (i_done) begin
               iwait = 1'b0;
               iload = ramload;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: fetch, data priority and alternation,
// request drop, RAM ERROR, timeout, and asynchronous reset mid-grant.
module tb_mem_arbiter;

   localparam int W = 32;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic         iREN = 1'b0;
   logic [W-1:0] iaddr = '0;
   logic         dREN = 1'b0;
   logic         dWEN = 1'b0;
   logic [W-1:0] daddr = '0;
   logic [W-1:0] dstore = '0;
   logic         iwait;
   logic         dwait;
   logic [W-1:0] iload;
   logic [W-1:0] dload;
   logic         ramREN;
   logic         ramWEN;
   logic [W-1:0] ramaddr;
   logic [W-1:0] ramstore;
   logic [W-1:0] ramload = '0;
   logic [1:0]   ramstate = 2'b00;
   logic         err;

   int checks = 0;
   int failures = 0;

   mem_arbiter #(.WORD_W(W), .TIMEOUT(16)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
      .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
      .err(err)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [W-1:0] got,
                        input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      // Reset values, waits follow requests during reset
      #3;
      check("rst_ren", 32'(ramREN), 32'd0);
      check("rst_wen", 32'(ramWEN), 32'd0);
      check("rst_addr", ramaddr, 32'd0);
      check("rst_err", 32'(err), 32'd0);
      iREN = 1'b1;
      #1;
      check("rst_iwait", 32'(iwait), 32'd1);
      check("rst_ren_req", 32'(ramREN), 32'd0);
      check("rst_iload", iload, 32'd0);
      iREN = 1'b0;
      tick;
      RST = 1'b0;

      // Instruction fetch, ACCESS on 2nd grant cycle
      tick;
      iREN = 1'b1; iaddr = 32'h40; ramstate = 2'b01;
      #1;
      check("if_idle_ren", 32'(ramREN), 32'd0);
      tick;
      check("if_g1_ren", 32'(ramREN), 32'd1);
      check("if_g1_addr", ramaddr, 32'h40);
      check("if_g1_iwait", 32'(iwait), 32'd1);
      tick;
      check("if_g2_hold", ramaddr, 32'h40);
      ramstate = 2'b10; ramload = 32'hDEADBEEF;
      #1;
      check("if_done_iwait", 32'(iwait), 32'd0);
      check("if_done_iload", iload, 32'hDEADBEEF);
      tick;
      iREN = 1'b0; ramstate = 2'b00;
      #1;
      check("if_idle_after", 32'(ramREN), 32'd0);
      check("if_iload_zero", iload, 32'd0);

      // Data priority, write wins over read, then alternate to fetch
      iREN = 1'b1; iaddr = 32'h44;
      dREN = 1'b1; dWEN = 1'b1; daddr = 32'h80; dstore = 32'h1234;
      ramstate = 2'b01;
      tick;
      check("d_wen", 32'(ramWEN), 32'd1);
      check("d_ren", 32'(ramREN), 32'd0);
      check("d_addr", ramaddr, 32'h80);
      check("d_store", ramstore, 32'h1234);
      check("d_iwait", 32'(iwait), 32'd1);
      ramstate = 2'b10; ramload = 32'h55;
      #1;
      check("d_done_dwait", 32'(dwait), 32'd0);
      check("d_done_dload", dload, 32'h55);
      check("d_done_iload", iload, 32'd0);
      tick;
      dREN = 1'b0; dWEN = 1'b0; ramstate = 2'b01;
      #1;
      check("alt_ren", 32'(ramREN), 32'd1);
      check("alt_wen", 32'(ramWEN), 32'd0);
      check("alt_addr", ramaddr, 32'h44);
      check("alt_store", ramstore, 32'd0);
      ramstate = 2'b10; ramload = 32'h99;
      #1;
      check("alt_iwait", 32'(iwait), 32'd0);
      check("alt_iload", iload, 32'h99);
      check("alt_dload", dload, 32'd0);
      tick;
      iREN = 1'b0; ramstate = 2'b00;
      #1;
      check("alt_idle", 32'(ramREN), 32'd0);

      // Data read, then request dropped before ACCESS
      dREN = 1'b1; daddr = 32'h10;
      tick;
      check("rd_ren", 32'(ramREN), 32'd1);
      check("rd_wen", 32'(ramWEN), 32'd0);
      dREN = 1'b0;
      #1;
      check("drop_ren", 32'(ramREN), 32'd0);
      tick;
      ramstate = 2'b10; ramload = 32'hAA;
      #1;
      check("drop_dload", dload, 32'd0);
      check("drop_addr", ramaddr, 32'd0);
      ramstate = 2'b00;

      // RAM ERROR in DGNT
      dWEN = 1'b1; daddr = 32'h20;
      tick;
      ramstate = 2'b11;
      #1;
      check("e_pre_err", 32'(err), 32'd0);
      tick;
      check("e_err", 32'(err), 32'd1);
      check("e_wen", 32'(ramWEN), 32'd0);
      check("e_dwait", 32'(dwait), 32'd1);
      dWEN = 1'b0; ramstate = 2'b00;
      tick;
      check("e_sticky", 32'(err), 32'd1);
      RST = 1'b1;
      #2;
      check("e_rst_clr", 32'(err), 32'd0);
      RST = 1'b0;

      // Timeout: BUSY for 16 grant cycles
      iREN = 1'b1; iaddr = 32'h8; ramstate = 2'b01;
      tick;
      check("t_g1_ren", 32'(ramREN), 32'd1);
      repeat (15) tick;
      check("t_g16_ren", 32'(ramREN), 32'd1);
      check("t_g16_err", 32'(err), 32'd0);
      tick;
      check("t_err", 32'(err), 32'd1);
      check("t_ren", 32'(ramREN), 32'd0);
      check("t_iwait", 32'(iwait), 32'd1);
      iREN = 1'b0;
      RST = 1'b1;
      #2;
      RST = 1'b0;

      // Async reset mid-DGNT, re-grant after release
      dWEN = 1'b1; daddr = 32'h30; dstore = 32'h77;
      tick;
      check("ar_wen", 32'(ramWEN), 32'd1);
      RST = 1'b1;
      #1;
      check("ar_wen_rst", 32'(ramWEN), 32'd0);
      check("ar_addr_rst", ramaddr, 32'd0);
      check("ar_dwait_rst", 32'(dwait), 32'd1);
      #1;
      RST = 1'b0;
      #1;
      check("ar_idle", 32'(ramWEN), 32'd0);
      tick;
      check("ar_regrant", 32'(ramWEN), 32'd1);
      check("ar_regrant_addr", ramaddr, 32'h30);
      check("ar_regrant_st", ramstore, 32'h77);
      dWEN = 1'b0; ramstate = 2'b00;
      tick;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
